// File: rtl/seq_priority_encoder16_if.sv
// Handshake bundle for seq_priority_encoder16: request word/load/ack in,
// index/valid/status out.
interface seq_priority_encoder16_if #(
  parameter int N  = 16,
  parameter int IW = 4
);
  logic          load;
  logic [N-1:0]  w;
  logic          ack;
  logic [IW-1:0] y;
  logic          v;
  logic          busy;
  logic          done;
  logic          z;
  logic [IW:0]   cnt;

  modport master (
    output load, w, ack,
    input  y, v, busy, done, z, cnt
  );

  modport slave (
    input  load, w, ack,
    output y, v, busy, done, z, cnt
  );
endinterface

// File: rtl/seq_priority_encoder16.sv
// Sequential 16-to-4 priority encoder: captures a request word and hands out
// the index of each set bit, highest first, one per accepted ack.
module seq_priority_encoder16 #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  seq_priority_encoder16_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          z_q, z_d;

  logic [IW-1:0] top_idx;
  logic [N-1:0]  top_onehot;

  // Ascending scan: the last set bit seen is the highest, so it wins.
  always_comb begin
    top_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pending_q[i]) top_idx = IW'(i);
    end
    top_onehot = {{(N-1){1'b0}}, 1'b1} << top_idx;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    z_d       = z_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          cnt_d = '0;
          if (bus.w == '0) begin
            z_d    = 1'b1;
            done_d = 1'b1;
          end else begin
            z_d       = 1'b0;
            pending_d = bus.w;
            state_d   = SCAN;
          end
        end
      end
      SCAN: begin
        if (bus.ack) begin
          pending_d = pending_q & ~top_onehot;
          cnt_d     = cnt_q + 1'b1;
          if (pending_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      z_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      z_q       <= z_d;
    end
  end

  assign bus.v    = (state_q == SCAN);
  assign bus.busy = (state_q == SCAN);
  assign bus.y    = (state_q == SCAN) ? top_idx : '0;
  assign bus.done = done_q;
  assign bus.z    = z_q;
  assign bus.cnt  = cnt_q;

endmodule
